// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: formats load data and registers the four write-back mux inputs plus register-file controls.
// Optional retire counter (output retire_count) is built when MEM_WB_RETIRE_CNT_EN is defined.
module mem_wb_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_mem_rdata,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic [XLEN-1:0] in_imm,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_reg_write,
  input  logic [1:0]      in_wb_src,
  input  logic [2:0]      in_funct3,
  input  logic [1:0]      in_addr_lo,
  output logic [XLEN-1:0] wb_in_0,
  output logic [XLEN-1:0] wb_in_1,
  output logic [XLEN-1:0] wb_in_2,
  output logic [XLEN-1:0] wb_in_3,
  output logic [1:0]      wb_sel,
  output logic [RD_W-1:0] wb_rd,
  output logic            wb_reg_write,
  output logic            wb_valid
`ifdef MEM_WB_RETIRE_CNT_EN
  ,
  output logic [31:0]     retire_count
`endif
);

  logic [7:0]      loadByte;
  logic [15:0]     loadHalf;
  logic [XLEN-1:0] loadData;

  logic [XLEN-1:0] aluRes_q, aluRes_d;
  logic [XLEN-1:0] loadData_q, loadData_d;
  logic [XLEN-1:0] pcPlus4_q, pcPlus4_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [1:0]      sel_q, sel_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic            regWrite_q, regWrite_d;
  logic            valid_q, valid_d;
  logic            capture;

  assign capture = !flush && !stall;

  // Unknown funct3 encodings fall through to the raw word, same as LW.
  always_comb begin
    case (in_addr_lo)
      2'd0:    loadByte = in_mem_rdata[7:0];
      2'd1:    loadByte = in_mem_rdata[15:8];
      2'd2:    loadByte = in_mem_rdata[23:16];
      default: loadByte = in_mem_rdata[31:24];
    endcase
    loadHalf = in_addr_lo[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];
    case (in_funct3)
      3'b000:  loadData = {{(XLEN-8){loadByte[7]}}, loadByte};
      3'b001:  loadData = {{(XLEN-16){loadHalf[15]}}, loadHalf};
      3'b100:  loadData = {{(XLEN-8){1'b0}}, loadByte};
      3'b101:  loadData = {{(XLEN-16){1'b0}}, loadHalf};
      default: loadData = in_mem_rdata;
    endcase
  end

  always_comb begin
    aluRes_d   = aluRes_q;
    loadData_d = loadData_q;
    pcPlus4_d  = pcPlus4_q;
    imm_d      = imm_q;
    sel_d      = sel_q;
    rd_d       = rd_q;
    regWrite_d = regWrite_q;
    valid_d    = valid_q;
    if (flush) begin
      aluRes_d   = '0;
      loadData_d = '0;
      pcPlus4_d  = '0;
      imm_d      = '0;
      sel_d      = '0;
      rd_d       = '0;
      regWrite_d = 1'b0;
      valid_d    = 1'b0;
    end else if (capture) begin
      aluRes_d   = in_alu_result;
      loadData_d = loadData;
      pcPlus4_d  = in_pc_plus4;
      imm_d      = in_imm;
      sel_d      = in_wb_src;
      rd_d       = in_rd;
      // x0 is hardwired to zero, so its write enable is dropped here.
      regWrite_d = in_reg_write & in_valid & (in_rd != '0);
      valid_d    = in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aluRes_q   <= '0;
      loadData_q <= '0;
      pcPlus4_q  <= '0;
      imm_q      <= '0;
      sel_q      <= '0;
      rd_q       <= '0;
      regWrite_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      aluRes_q   <= aluRes_d;
      loadData_q <= loadData_d;
      pcPlus4_q  <= pcPlus4_d;
      imm_q      <= imm_d;
      sel_q      <= sel_d;
      rd_q       <= rd_d;
      regWrite_q <= regWrite_d;
      valid_q    <= valid_d;
    end
  end

  assign wb_in_0      = aluRes_q;
  assign wb_in_1      = loadData_q;
  assign wb_in_2      = pcPlus4_q;
  assign wb_in_3      = imm_q;
  assign wb_sel       = sel_q;
  assign wb_rd        = rd_q;
  assign wb_reg_write = regWrite_q;
  assign wb_valid     = valid_q;

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] retireCount_q, retireCount_d;

  // Counts only real instructions actually entering WB; wraps naturally.
  always_comb begin
    retireCount_d = retireCount_q;
    if (capture && in_valid) retireCount_d = retireCount_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) retireCount_q <= '0;
    else     retireCount_q <= retireCount_d;
  end

  assign retire_count = retireCount_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: randomized stimulus against a behavioural model of the stage.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst, stall, flush, in_valid, in_reg_write;
  logic [31:0] in_alu_result, in_mem_rdata, in_pc_plus4, in_imm;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_src, in_addr_lo;
  logic [2:0]  in_funct3;
  logic [31:0] wb_in_0, wb_in_1, wb_in_2, wb_in_3;
  logic [1:0]  wb_sel;
  logic [4:0]  wb_rd;
  logic        wb_reg_write, wb_valid;
`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] retire_count;
`endif

  int compared = 0;
  int mismatched = 0;

  logic [31:0] eIn0, eIn1, eIn2, eIn3, eCnt;
  logic [1:0]  eSel;
  logic [4:0]  eRd;
  logic        eRw, eValid;
  logic [136:0] actVec, expVec;

  assign actVec = {wb_in_0, wb_in_1, wb_in_2, wb_in_3, wb_sel, wb_rd, wb_reg_write, wb_valid};
  assign expVec = {eIn0, eIn1, eIn2, eIn3, eSel, eRd, eRw, eValid};

  mem_wb_stage #(.XLEN(32), .RD_W(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
    .in_pc_plus4(in_pc_plus4), .in_imm(in_imm), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_wb_src(in_wb_src), .in_funct3(in_funct3),
    .in_addr_lo(in_addr_lo),
    .wb_in_0(wb_in_0), .wb_in_1(wb_in_1), .wb_in_2(wb_in_2), .wb_in_3(wb_in_3),
    .wb_sel(wb_sel), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_valid(wb_valid)
`ifdef MEM_WB_RETIRE_CNT_EN
    , .retire_count(retire_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Load data expressed as shifts and two's-complement arithmetic.
  function automatic logic [31:0] fmtLoad(logic [31:0] d, logic [2:0] f3, logic [1:0] lo);
    int unsigned b, h;
    b = (d >> (8 * int'(lo))) & 32'hFF;
    h = (d >> (16 * int'(lo[1]))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? 32'(b - 256) : 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return d;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst || flush) begin
      {eIn0, eIn1, eIn2, eIn3, eSel, eRd, eRw, eValid} = '0;
      if (rst) eCnt = 32'd0;
    end else if (!stall) begin
      eIn0 = in_alu_result;
      eIn1 = fmtLoad(in_mem_rdata, in_funct3, in_addr_lo);
      eIn2 = in_pc_plus4;
      eIn3 = in_imm;
      eSel = in_wb_src;
      eRd = in_rd;
      eRw = in_reg_write && in_valid && (in_rd != 5'd0);
      eValid = in_valid;
      if (in_valid) eCnt = eCnt + 32'd1;
    end
    #1;
  endtask

  task automatic applyStimulus();
    in_valid = 1'($urandom);
    in_alu_result = $urandom;
    in_addr_lo = in_alu_result[1:0];
    in_mem_rdata = $urandom;
    in_pc_plus4 = $urandom;
    in_imm = $urandom;
    in_rd = 5'($urandom);
    in_reg_write = 1'($urandom);
    in_wb_src = 2'($urandom);
    in_funct3 = 3'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    applyStimulus();
    tick();
    applyStimulus();
    tick();
    compared++;
    if (actVec !== 137'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs got=%h want=0", actVec);
    end
    rst = 1'b0;
    applyStimulus();
    in_valid = 1'b1; in_alu_result = 32'h12345678; in_addr_lo = 2'd0;
    in_wb_src = 2'd0; in_rd = 5'd5; in_reg_write = 1'b1;
    tick();
    compared++;
    if ({wb_in_0, wb_sel, wb_rd, wb_reg_write, wb_valid} !== {32'h12345678, 2'd0, 5'd5, 1'b1, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL first_capture got=%h/%0d/%0d/%b/%b want=12345678/0/5/1/1",
               wb_in_0, wb_sel, wb_rd, wb_reg_write, wb_valid);
    end
    compared++;
    if (actVec !== expVec) begin
      mismatched++;
      $display("[TB] FAIL first_capture_model got=%h want=%h", actVec, expVec);
    end
  endtask

  task automatic test_load_format();
    logic [2:0]  f3Tab  [8] = '{3'd0, 3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd1, 3'd3};
    logic [1:0]  offTab [8] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd0, 2'd3, 2'd1};
    logic [31:0] wantTab[8] = '{32'h0000007F, 32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF,
                                32'h00007F01, 32'h80FF7F01, 32'hFFFF80FF, 32'h80FF7F01};
    for (int i = 0; i < 8; i++) begin
      applyStimulus();
      in_mem_rdata = 32'h80FF7F01;
      in_funct3 = f3Tab[i];
      in_alu_result = {in_alu_result[31:2], offTab[i]};
      in_addr_lo = offTab[i];
      tick();
      compared++;
      if (wb_in_1 !== wantTab[i]) begin
        mismatched++;
        $display("[TB] FAIL load_fmt_%0d f3=%0d off=%0d got=%h want=%h",
                 i, f3Tab[i], offTab[i], wb_in_1, wantTab[i]);
      end
    end
    for (int i = 0; i < 40; i++) begin
      applyStimulus();
      tick();
      compared++;
      if (actVec !== expVec) begin
        mismatched++;
        $display("[TB] FAIL load_rand_%0d got=%h want=%h", i, actVec, expVec);
      end
    end
  endtask

  task automatic test_x0();
    applyStimulus();
    in_rd = 5'd0; in_reg_write = 1'b1; in_valid = 1'b1;
    tick();
    compared++;
    if ({wb_reg_write, wb_valid} !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL x0_suppress got=%b%b want=01", wb_reg_write, wb_valid);
    end
    applyStimulus();
    in_rd = 5'd31; in_reg_write = 1'b1; in_valid = 1'b0;
    tick();
    compared++;
    if ({wb_reg_write, wb_valid} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL invalid_no_write got=%b%b want=00", wb_reg_write, wb_valid);
    end
  endtask

  task automatic test_stall_flush();
    logic [136:0] snapA;
    applyStimulus();
    in_valid = 1'b1; in_reg_write = 1'b1; in_rd = 5'd9;
    tick();
    snapA = expVec;
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1;
      applyStimulus();
      tick();
      compared++;
      if (actVec !== snapA) begin
        mismatched++;
        $display("[TB] FAIL stall_hold_%0d got=%h want=%h", i, actVec, snapA);
      end
    end
    flush = 1'b1;
    applyStimulus();
    tick();
    compared++;
    if (actVec !== 137'd0) begin
      mismatched++;
      $display("[TB] FAIL flush_over_stall got=%h want=0", actVec);
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_link_lui();
    applyStimulus();
    in_wb_src = 2'd2; in_pc_plus4 = 32'h00000104; in_imm = 32'hABCDE000;
    tick();
    compared++;
    if ({wb_sel, wb_in_2, wb_in_3} !== {2'd2, 32'h00000104, 32'hABCDE000}) begin
      mismatched++;
      $display("[TB] FAIL link_lui got=%0d/%h/%h want=2/00000104/abcde000", wb_sel, wb_in_2, wb_in_3);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 200; i++) begin
      applyStimulus();
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      tick();
      compared++;
      if (actVec !== expVec) begin
        mismatched++;
        $display("[TB] FAIL random_%0d st=%b fl=%b got=%h want=%h", i, stall, flush, actVec, expVec);
      end
`ifdef MEM_WB_RETIRE_CNT_EN
      compared++;
      if (retire_count !== eCnt) begin
        mismatched++;
        $display("[TB] FAIL random_count_%0d got=%h want=%h", i, retire_count, eCnt);
      end
`endif
    end
    stall = 1'b0; flush = 1'b0;
  endtask

`ifdef MEM_WB_RETIRE_CNT_EN
  task automatic test_retire_count();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus();
      in_valid = 1'b1;
      stall = (i == 4);
      flush = (i == 8);
      tick();
    end
    stall = 1'b0; flush = 1'b0;
    compared++;
    if (retire_count !== 32'd10) begin
      mismatched++;
      $display("[TB] FAIL retire_count_10 got=%0d want=10", retire_count);
    end
    dut.retireCount_q = 32'hFFFFFFFF;
    eCnt = 32'hFFFFFFFF;
    applyStimulus();
    in_valid = 1'b1;
    tick();
    compared++;
    if (retire_count !== 32'h00000000) begin
      mismatched++;
      $display("[TB] FAIL retire_count_wrap got=%h want=00000000", retire_count);
    end
  endtask
`endif

  initial begin
    eCnt = 32'd0;
    {eIn0, eIn1, eIn2, eIn3, eSel, eRd, eRw, eValid} = '0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    applyStimulus();
    test_reset();
    test_load_format();
    test_x0();
    test_stall_flush();
    test_link_lui();
    test_back_to_back();
`ifdef MEM_WB_RETIRE_CNT_EN
    test_retire_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
